// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   pipe_state_t    : occupancy state of the stage (EMPTY, FULL, SKID). The
//                     encoding equals the entry count, so it drives occ_o as is.
//   PIPE_CTRL_W_DEF : default control payload width.
//   PIPE_DATA_W_DEF : default data payload width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int PIPE_CTRL_W_DEF = 8;
  localparam int PIPE_DATA_W_DEF = 64;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus control and data payload registers.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears everything)
//   load          : capture ctrl_d/data_d and mark the slot valid
//   clear         : mark the slot invalid (wins over load); data is kept
//   ctrl_d/data_d : payload to capture
//   valid         : slot holds an entry
//   ctrl          : control payload, forced to zero while the slot is invalid
//   data          : data payload, holds its last value while invalid
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block evaluation order.
  // NOTE: the payload registers are reset too, not only valid: data_o must
  // read zero after reset, and the slot is only a handful of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  // A bubble must look like a NOP downstream, so control is gated by valid.
  assign valid = valid_q;
  assign ctrl  = valid_q ? ctrl_q : '0;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, backpressure stall
// and synchronous flush that inserts a bubble (control zeroed).
// Build option: PIPE_STAGE_SKID_EN
//   defined   : main slot M plus skid slot S, three-state FSM, ready_o from a
//               flop (no ready_i -> ready_o path), occ_o up to 2.
//   undefined : main slot M only, ready_o = !valid_o | ready_i, occ_o <= 1.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset (overrides all)
//   flush_i          : squash held entries and drop this cycle's input
//   valid_i, ready_o : upstream handshake; ctrl_i/data_i upstream payload
//   valid_o, ready_i : downstream handshake; ctrl_o/data_o downstream payload
//   occ_o            : number of held entries after the current edge
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic              accept;
  logic              emit;
  logic              m_valid;
  logic              m_load;
  logic              m_clear;
  logic [CTRL_W-1:0] m_ctrl_d;
  logic [DATA_W-1:0] m_data_d;

  assign accept  = valid_i & ready_o;
  assign emit    = m_valid & ready_i;
  assign valid_o = m_valid;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (m_load),
    .clear  (m_clear),
    .ctrl_d (m_ctrl_d),
    .data_d (m_data_d),
    .valid  (m_valid),
    .ctrl   (ctrl_o),
    .data   (data_o)
  );

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_t       state;
  pipe_state_t       state_n;
  logic              ready_q;
  logic              s_load;
  logic              s_clear;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  // The skid slot only ever captures straight from the upstream inputs.
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (s_load),
    .clear  (s_clear),
    .ctrl_d (ctrl_i),
    .data_d (data_i),
    .valid  (s_valid),
    .ctrl   (s_ctrl),
    .data   (s_data)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_n  = state;
    m_load   = 1'b0;
    m_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    m_ctrl_d = ctrl_i;
    m_data_d = data_i;
    if (flush_i) begin
      state_n = EMPTY;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_n = FULL;
          end
        end
        FULL: begin
          if (accept && emit) begin
            m_load = 1'b1;
          end else if (accept) begin
            // Downstream stalled this cycle: park the new entry in S.
            s_load  = 1'b1;
            state_n = SKID;
          end else if (emit) begin
            m_clear = 1'b1;
            state_n = EMPTY;
          end
        end
        SKID: begin
          // S is always valid here; the guard keeps a bubble from ever
          // being promoted into M as if it were an entry.
          if (emit && s_valid) begin
            m_load   = 1'b1;
            m_ctrl_d = s_ctrl;
            m_data_d = s_data;
            s_clear  = 1'b1;
            state_n  = FULL;
          end
        end
        default: begin
          state_n = EMPTY;
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end

  // ready_o is a flop computed from the next state, so it never depends
  // combinationally on ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != SKID);
    end
  end

  assign ready_o = ready_q;
  assign occ_o   = state;

`else

  // Single slot: accept whenever the slot is empty or is being drained.
  always_comb begin
    m_load   = accept & ~flush_i;
    m_clear  = flush_i | (emit & ~accept);
    m_ctrl_d = ctrl_i;
    m_data_d = data_i;
  end

  assign ready_o = ~m_valid | ready_i;
  assign occ_o   = {1'b0, m_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (either PIPE_STAGE_SKID_EN build).
// A queue-based model of the stage (capacity 1 or 2) is advanced on every
// rising edge; one compare process checks all outputs against it on every
// falling edge. Directed sequences add literal expectations, then a long
// randomized run exercises handshakes, flush and reset.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        occ_o;

  ent_t        mq[$];
  logic [63:0] last_data = '0;
  bit          model_ok  = 1'b0;
  bit          watch_44  = 1'b0;
  int          seen_44   = 0;
  int          checks    = 0;
  int          errors    = 0;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ctrl_o  (ctrl_o),
    .data_o  (data_o),
    .occ_o   (occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The stage can take a new entry when it has room: two slots with skid,
  // otherwise one slot that may be freed by a same-cycle emit.
  function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (ready_i == 1'b1);
`endif
  endfunction

  task automatic model_step();
    logic acc;
    logic emt;
    acc = valid_i && exp_ready();
    emt = (mq.size() != 0) && (ready_i == 1'b1);
    if (rst_i) begin
      mq.delete();
      last_data = '0;
      model_ok  = 1'b1;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back('{ctrl: ctrl_i, data: data_i});
    end
    if (mq.size() != 0) last_data = mq[0].data;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d,
                       input logic r, input logic f, input logic rs);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    rst_i   = rs;
  endtask

  // Single compare process: every output against the model, every cycle.
  always @(negedge clk_i) begin
    logic ev;
    if (model_ok) begin
      ev = (mq.size() != 0);
      check("valid_o", 64'(valid_o), 64'(ev));
      check("ready_o", 64'(ready_o), 64'(exp_ready()));
      check("ctrl_o", 64'(ctrl_o), ev ? 64'(mq[0].ctrl) : 64'd0);
      check("data_o", data_o, ev ? mq[0].data : last_data);
      check("occ_o", 64'(occ_o), 64'(mq.size()));
      if (watch_44 && valid_o && data_o == 64'h44) seen_44++;
    end
  end

  initial begin
    // Reset held two cycles with a live input that must be ignored.
    drive(1'b1, 8'hFF, 64'h1234, 1'b1, 1'b0, 1'b1);
    tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ctrl", 64'(ctrl_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_occ", 64'(occ_o), 64'd0);
    tick();
    check("rst2_valid", 64'(valid_o), 64'd0);
    check("rst2_occ", 64'(occ_o), 64'd0);
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("rst_rel_ready", 64'(ready_o), 64'd1);
    tick();
    check("rst_rel_ready2", 64'(ready_o), 64'd1);

    // Streaming 1..16 with ready_i high: one cycle latency, no gaps.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 64'(i), 1'b1, 1'b0, 1'b0);
      tick();
      check("stream_valid", 64'(valid_o), 64'd1);
      check("stream_data", data_o, 64'(i));
      check("stream_ctrl", 64'(ctrl_o), 64'(i));
    end
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_drained", 64'(valid_o), 64'd0);
    check("model_empty", 64'(mq.size()), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure from the cycle B arrives: B goes to S, C is refused.
    drive(1'b1, 8'h01, 64'h11, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_a", data_o, 64'h11);
    drive(1'b1, 8'h02, 64'h22, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp_ready_b", 64'(ready_o), 64'd1);
    tick();
    check("bp_hold_a", data_o, 64'h11);
    check("bp_occ2", 64'(occ_o), 64'd2);
    check("bp_ready0", 64'(ready_o), 64'd0);
    check("model_occ2", 64'(mq.size()), 64'd2);
    drive(1'b1, 8'h03, 64'h33, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_hold_a2", data_o, 64'h11);
    check("bp_occ2b", 64'(occ_o), 64'd2);
    drive(1'b1, 8'h03, 64'h33, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp_b", data_o, 64'h22);
    check("bp_occ1", 64'(occ_o), 64'd1);
    check("bp_ready1", 64'(ready_o), 64'd1);
    tick();
    check("bp_c", data_o, 64'h33);

    // Fill to two entries, then flush with a live 0x44 input.
    drive(1'b1, 8'h05, 64'h55, 1'b0, 1'b0, 1'b0);
    tick();
    check("fl_occ2", 64'(occ_o), 64'd2);
    watch_44 = 1'b1;
    drive(1'b1, 8'h04, 64'h44, 1'b0, 1'b1, 1'b0);
    tick();
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ctrl", 64'(ctrl_o), 64'd0);
    check("fl_occ", 64'(occ_o), 64'd0);
    check("fl_data_held", data_o, 64'h33);
`else
    // ready_i toggles 1,0,1,0 under continuous input; upstream holds its
    // entry until it is taken, so after edge k the output is 0x60 + k/2.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(k / 2), 64'h60 + 64'(k / 2), (k % 2) == 0, 1'b0, 1'b0);
      #1;
      check("tog_ready", 64'(ready_o), 64'((k % 2) == 0));
      tick();
      check("tog_data", data_o, 64'h60 + 64'(k / 2));
      check("tog_valid", 64'(valid_o), 64'd1);
    end
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("tog_drained", 64'(valid_o), 64'd0);

    // Flush with a live 0x44 input while ready_o is high.
    drive(1'b1, 8'h07, 64'h77, 1'b1, 1'b0, 1'b0);
    tick();
    check("fl_load", data_o, 64'h77);
    check("fl_occ1", 64'(occ_o), 64'd1);
    watch_44 = 1'b1;
    drive(1'b1, 8'h04, 64'h44, 1'b1, 1'b1, 1'b0);
    #1;
    check("fl_ready", 64'(ready_o), 64'd1);
    tick();
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ctrl", 64'(ctrl_o), 64'd0);
    check("fl_occ", 64'(occ_o), 64'd0);
    check("fl_data_held", data_o, 64'h77);
`endif
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();

    // Flush and reset together: reset wins.
    drive(1'b1, 8'h09, 64'h99, 1'b0, 1'b0, 1'b0);
    tick();
    check("fr_loaded", 64'(occ_o), 64'd1);
    drive(1'b1, 8'hFF, 64'hAA, 1'b1, 1'b1, 1'b1);
    tick();
    check("fr_valid", 64'(valid_o), 64'd0);
    check("fr_ctrl", 64'(ctrl_o), 64'd0);
    check("fr_data", data_o, 64'd0);
    check("fr_occ", 64'(occ_o), 64'd0);
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("fr_ready", 64'(ready_o), 64'd1);
    tick();
    check("no_44", 64'(seen_44), 64'd0);
    watch_44 = 1'b0;

    // Randomized handshakes with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(3) != 0, 8'($urandom), {$urandom, $urandom},
            $urandom_range(3) != 0, $urandom_range(31) == 0,
            $urandom_range(255) == 0);
      tick();
    end
    drive(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    check("end_empty", 64'(valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
